// File: rtl/uart_pkg.sv
// Shared UART constants and state type for the receive, transmit
// and display-counter paths.
package uart_pkg;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned UART_BAUD = 9600;
  localparam int unsigned UART_CLK_DIV =
    (CLK_FREQ_HZ + UART_BAUD / 2) / UART_BAUD;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_bit_sync.sv
// Two-flop synchronizer with falling-edge detect for async inputs.
// All flops reset high so an idle-high line reports no edge.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_fell
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s2_d <= 1'b1;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_fell = r_s2_d & ~r_s2;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid and
// framing-error strobes, last good byte held on rx_data.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_DIV = CLK_DIV / 2;
  localparam logic [15:0] HALF_M1 = 16'(HALF_DIV - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);

  logic      w_rx_s;
  logic      w_fell;
  rx_state_t r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;

  bit_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s),
    .o_fell  (w_fell)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_fell) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            // a low stop bit discards the byte
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized bench for uart_byte_rx against a frame-level model:
// each sent frame predicts either a byte or a framing error.
module tb_uart_byte_rx;

  localparam int DIV  = 16;
  localparam int DIVB = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rxb = 1'b1;
  logic [7:0] rx_data, rx_data_b;
  logic       rx_valid, rx_valid_b;
  logic       frame_err, frame_err_b;
  logic       busy, busy_b;

  always #5 clk = ~clk;

  uart_byte_rx #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  uart_byte_rx #(.CLK_DIV(DIVB)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .rx        (rxb),
    .rx_data   (rx_data_b),
    .rx_valid  (rx_valid_b),
    .frame_err (frame_err_b),
    .busy      (busy_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] q_a[$], exp_a[$];
  logic [7:0] q_b[$], exp_b[$];
  int ferr_a = 0, ferr_b = 0, both_a = 0;
  int busy_late_a = 0;
  bit busy_seen_a = 0;
  bit pv_a = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) q_a.push_back(rx_data);
      if (frame_err) ferr_a++;
      if (rx_valid && frame_err) both_a++;
      if (busy) busy_seen_a = 1;
      if (pv_a && busy) busy_late_a++;
      pv_a = rx_valid;
      if (rx_valid_b) q_b.push_back(rx_data_b);
      if (frame_err_b) ferr_b++;
    end
  end

  task automatic put(input bit sel, input logic v, input int n);
    if (sel) rxb = v;
    else rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input logic stopb, input int per);
    put(sel, 1'b0, per);
    for (int i = 0; i < 8; i++) put(sel, d[i], per);
    put(sel, stopb, per);
  endtask

  task automatic send_a(input logic [7:0] d);
    exp_a.push_back(d);
    last_good = d;
    send(1'b0, d, 1'b1, DIV);
  endtask

  task automatic compare_a(input string tag);
    check({tag, "_count"}, q_a.size(), exp_a.size());
    while (q_a.size() > 0 && exp_a.size() > 0)
      check(tag, q_a.pop_front(), exp_a.pop_front());
    q_a.delete();
    exp_a.delete();
  endtask

  task automatic compare_b(input string tag);
    check({tag, "_count"}, q_b.size(), exp_b.size());
    while (q_b.size() > 0 && exp_b.size() > 0)
      check(tag, q_b.pop_front(), exp_b.pop_front());
    q_b.delete();
    exp_b.delete();
  endtask

  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int fe0;

    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    put(0, 1'b1, 2 * DIV);

    send_a(8'hA5);
    put(0, 1'b1, 2 * DIV);
    compare_a("a5");
    check("a5_ferr", ferr_a, 0);

    send_a(8'h00);
    send_a(8'hFF);
    for (int k = 0; k < 4; k++) send_a(8'($urandom_range(0, 255)));
    put(0, 1'b1, 2 * DIV);
    compare_a("b2b");

    for (int k = 0; k < 4; k++) begin
      send_a(8'($urandom_range(0, 255)));
      put(0, 1'b1, $urandom_range(1, 2 * DIV));
    end
    put(0, 1'b1, 2 * DIV);
    compare_a("gap");

    busy_seen_a = 0;
    fe0 = ferr_a;
    put(0, 1'b0, 3);
    put(0, 1'b1, 3 * DIV);
    check("glitch_busy_seen", busy_seen_a, 1'b1);
    check("glitch_busy_now", busy, 1'b0);
    check("glitch_ferr", ferr_a, fe0);
    compare_a("glitch");

    fe0 = ferr_a;
    send(1'b0, 8'h3C, 1'b0, DIV);
    put(0, 1'b0, 40);
    check("ferr_pulse", ferr_a, fe0 + 1);
    check("ferr_hold_data", rx_data, last_good);
    check("ferr_no_retrig", busy, 1'b0);
    compare_a("ferr");
    put(0, 1'b1, 2 * DIV);
    check("ferr_release_idle", busy, 1'b0);
    d = 8'($urandom_range(0, 255));
    send_a(d);
    put(0, 1'b1, 2 * DIV);
    compare_a("after_ferr");

    fe0 = ferr_a;
    d = 8'h5A;
    put(0, 1'b0, DIV);
    for (int i = 0; i < 5; i++) put(0, d[i], DIV);
    rx = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    put(0, 1'b1, 3 * DIV);
    send_a(8'h81);
    put(0, 1'b1, 2 * DIV);
    compare_a("midrst");
    check("midrst_ferr", ferr_a, fe0);

    exp_b.push_back(8'h55);
    send(1'b1, 8'h55, 1'b1, DIVB * 97 / 100);
    put(1, 1'b1, 2 * DIVB);
    exp_b.push_back(8'h55);
    send(1'b1, 8'h55, 1'b1, DIVB * 103 / 100);
    put(1, 1'b1, 2 * DIVB);
    compare_b("baud_tol");
    check("baud_ferr", ferr_b, 0);

    check("ferr_total", ferr_a, 1);
    check("never_both", both_a, 0);
    check("busy_after_pulse", busy_late_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
